imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Loads a program image into the instruction memory over the UART byte stream, replacing the fixed ROM image without resynthesis. While a load is in progress the block holds the single-cycle CPU and owns the instruction-memory address. When the image is verified it releases the CPU with a restart pulse so execution begins at word 0. It sits between the UART receiver, the instruction memory write port and the CPU fetch path.

## Interface
- `ADDR_W`, 8: instruction-memory word-address width (PC bits [ADDR_W+1:2]); capacity 2^ADDR_W words.
- `TIMEOUT`, 1000000: idle clock cycles allowed between bytes once a frame has started.
- `SYNC_BYTE`, 8'hA5: frame start marker.

Ports:
- `clk`  in  1  system clock; the block uses this one clock only.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load.
- `rx_data`  in  8  received UART byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in that cycle.
- `cpu_pc`  in  32  CPU fetch address.
- `imem_addr`  out  ADDR_W  memory address: `imem_waddr` while `cpu_hold`=1, else `cpu_pc[ADDR_W+1:2]`. Combinational.
- `imem_we`  out  1  write strobe, one cycle per word.
- `imem_waddr`  out  ADDR_W  word index being written.
- `imem_wdata`  out  32  assembled word.
- `cpu_hold`  out  1  CPU must not advance its PC or write registers or memory.
- `boot_pulse`  out  1  one-cycle CPU restart to PC 0.
- `load_done`  out  1  last load succeeded; stays high until the next accepted `start`.
- `load_err`  out  1  last load failed; stays high until the next accepted `start`.

## Operation
- Frame format: `SYNC_BYTE`, then LEN_H and LEN_L (word count N, big-endian), then N×4 data bytes (each word MSB first), then CSUM = XOR of all data bytes.
- States: IDLE, SYNC, LEN_H, LEN_L, DATA, CSUM, DONE, ERR.
- IDLE, DONE, ERR:
  - `start` → SYNC; set `cpu_hold`=1; clear `load_done`, `load_err`, the checksum, the byte counter and the word counter.
  - `rx_valid` is ignored in these states.
  - If `start` and `rx_valid` occur in the same cycle, `start` wins and the byte is dropped.
- SYNC:
  - A byte equal to `SYNC_BYTE` → LEN_H.
  - Any other byte is discarded.
  - No timeout in SYNC.
- LEN_H → LEN_L: latch the length high byte.
- LEN_L: latch the low byte, then check N.
  - N=0 or N>2^ADDR_W → ERR.
  - Otherwise → DATA.
- DATA:
  - Shift each byte into the word (first byte lands in [31:24]) and XOR it into the checksum.
  - On the 4th byte of a word: register `imem_wdata`, set `imem_waddr` to the word counter, pulse `imem_we`, then increment the word counter.
  - After word N-1 is written → CSUM.
- CSUM:
  - Byte equal to the checksum → DONE: `cpu_hold`=0, `boot_pulse`=1 for one cycle, `load_done`=1.
  - Mismatch → ERR: `load_err`=1, `cpu_hold` stays 1, no `boot_pulse`.
- Timeout (LEN_H, LEN_L, DATA, CSUM only):
  - The counter clears on every accepted byte.
  - After TIMEOUT consecutive cycles with no `rx_valid` → ERR.
- `start` in SYNC through CSUM is ignored.
- Words already written before an error stay in memory; the CPU is held until a successful reload or reset.

## Timing
- Reset values:
  - state IDLE
  - `cpu_hold`, `imem_we`, `boot_pulse`, `load_done`, `load_err` = 0
  - `imem_waddr`, `imem_wdata` = 0
- Reset leaves the CPU running the image already in memory.
- Every input is sampled on the rising edge. A byte accepted at edge k affects state and outputs from cycle k+1.
- `imem_we`:
  - High exactly in the cycle after the edge that sampled the word's 4th byte.
  - `imem_waddr` and `imem_wdata` are stable during that cycle.
  - Back-to-back `rx_valid` still gives at most one write per 4 cycles.
- `cpu_hold`: rises the cycle after an accepted `start`; falls in the same cycle `boot_pulse` is high.
- `imem_addr`: switches source combinationally with `cpu_hold`; no added latency.
- Reset asserted mid-load:
  - All outputs return to their reset values at the next edge.
  - Partial memory contents are not rolled back.
- Counters and checksum:
  - The word counter is ADDR_W+1 bits, so N=2^ADDR_W completes without wrap.
  - The timeout counter saturates at TIMEOUT.

## Test plan
- **Good load.** Reset, `start`, then bytes A5 00 02 3C 11 40 00 26 31 00 04 7E.
  - Required: writes 0→32'h3C114000 and 1→32'h26310004.
  - Required: `boot_pulse` for one cycle; `load_done`=1; `cpu_hold`=0.
- **Bad checksum.** Same frame with CSUM 7F.
  - Required: `load_err`=1; `cpu_hold` stays 1; no `boot_pulse`; both writes still occurred.
- **Bad length.** Length 00 00 gives ERR right after LEN_L with no `imem_we`. With ADDR_W=8, length 01 01 gives ERR.
- **Noise before sync.** Bytes 00 FF 5A, then a valid frame.
  - Required: noise is ignored; the load completes identically to the good-load case.
- **Timeout.** TIMEOUT=16; send A5 00 01 3C 11, then stop.
  - Required: ERR exactly 16 cycles after the edge that sampled 11; no `imem_we`; `start` issued during DATA had no effect.
- **Reset mid-DATA.** Assert `reset` low during DATA.
  - Required: all outputs at reset values next cycle; `imem_addr` follows `cpu_pc[9:2]`.
  - Required: a subsequent full load succeeds.

Source files
------------

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - loads a framed program image from the UART byte stream into instruction memory
module imem_boot_loader #(
    parameter int          ADDR_W    = 8,
    parameter int          TIMEOUT   = 1000000,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic [31:0]       cpu_pc,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              boot_pulse,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SYNC  = 3'd1;
    localparam logic [2:0] S_LEN_H = 3'd2;
    localparam logic [2:0] S_LEN_L = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_CSUM  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;

    localparam int              TW      = $clog2(TIMEOUT + 1);
    localparam logic [16:0]     MAX_LEN = 17'd1 << ADDR_W;
    localparam logic [ADDR_W:0] ONE_W   = 1;

    logic [2:0]        state;
    logic [7:0]        len_h;
    logic [15:0]       len;
    logic [ADDR_W:0]   word_cnt;
    logic [1:0]        byte_cnt;
    logic [23:0]       shift;
    logic [7:0]        csum;
    logic [TW-1:0]     tmo_cnt;
    logic [15:0]       len_full;
    logic [ADDR_W:0]   word_next;
    logic              unused_pc_bits;

    assign len_full       = {len_h, rx_data};
    assign word_next      = word_cnt + ONE_W;
    assign imem_addr      = cpu_hold ? imem_waddr : cpu_pc[ADDR_W+1:2];
    assign unused_pc_bits = ^{cpu_pc[31:ADDR_W+2], cpu_pc[1:0]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            len_h      <= '0;
            len        <= '0;
            word_cnt   <= '0;
            byte_cnt   <= '0;
            shift      <= '0;
            csum       <= '0;
            tmo_cnt    <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b0;
            boot_pulse <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            imem_we    <= 1'b0;
            boot_pulse <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    // start has priority; a byte arriving alongside it is dropped
                    if (start) begin
                        state     <= S_SYNC;
                        cpu_hold  <= 1'b1;
                        load_done <= 1'b0;
                        load_err  <= 1'b0;
                        csum      <= '0;
                        byte_cnt  <= '0;
                        word_cnt  <= '0;
                        tmo_cnt   <= '0;
                    end
                end
                S_SYNC: begin
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        state   <= S_LEN_H;
                        tmo_cnt <= '0;
                    end
                end
                default: begin
                    if (rx_valid) begin
                        tmo_cnt <= '0;
                        if (state == S_LEN_H) begin
                            len_h <= rx_data;
                            state <= S_LEN_L;
                        end else if (state == S_LEN_L) begin
                            if (len_full == 16'd0 || {1'b0, len_full} > MAX_LEN) begin
                                state    <= S_ERR;
                                load_err <= 1'b1;
                            end else begin
                                len   <= len_full;
                                state <= S_DATA;
                            end
                        end else if (state == S_DATA) begin
                            shift    <= {shift[15:0], rx_data};
                            csum     <= csum ^ rx_data;
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3) begin
                                imem_wdata <= {shift, rx_data};
                                imem_waddr <= word_cnt[ADDR_W-1:0];
                                imem_we    <= 1'b1;
                                word_cnt   <= word_next;
                                if (17'(word_next) == {1'b0, len})
                                    state <= S_CSUM;
                            end
                        end else begin
                            if (rx_data == csum) begin
                                state      <= S_DONE;
                                cpu_hold   <= 1'b0;
                                boot_pulse <= 1'b1;
                                load_done  <= 1'b1;
                            end else begin
                                state    <= S_ERR;
                                load_err <= 1'b1;
                            end
                        end
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        state    <= S_ERR;
                        load_err <= 1'b1;
                    end else if (tmo_cnt != TW'(TIMEOUT)) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - self-checking bench for imem_boot_loader
module tb_imem_boot_loader;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic [31:0]       cpu_pc = 32'h0;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              boot_pulse;
    logic              load_done;
    logic              load_err;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int we_cnt   = 0;
    int boot_cnt = 0;
    logic [31:0] mem_model [256];
    logic [31:0] words [$];

    imem_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .cpu_pc(cpu_pc), .imem_addr(imem_addr), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .boot_pulse(boot_pulse),
        .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    // Memory image as seen through the write port
    always @(negedge clk) begin
        if (imem_we) begin
            we_cnt++;
            mem_model[imem_waddr] = imem_wdata;
        end
        if (boot_pulse) boot_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        we_cnt   = 0;
        boot_cnt = 0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_cnt++;
        if ({cpu_hold, load_done, load_err} !== 3'b100) begin
            $display("FAIL start_flags got=%b exp=100", {cpu_hold, load_done, load_err});
        end else pass_cnt++;
    endtask

    task automatic run_frame(input bit corrupt, input int maxgap, input int n_noise);
        logic [7:0] cs;
        logic [7:0] b;
        logic [15:0] n;
        int bad;
        cs = 8'h00;
        n  = 16'(words.size());
        pulse_start();
        for (int i = 0; i < n_noise; i++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h00;
            send_byte(b);
            idle($urandom_range(0, maxgap));
        end
        send_byte(8'hA5);
        idle($urandom_range(0, maxgap));
        send_byte(n[15:8]);
        idle($urandom_range(0, maxgap));
        send_byte(n[7:0]);
        idle($urandom_range(0, maxgap));
        for (int i = 0; i < int'(n); i++) begin
            for (int k = 0; k < 4; k++) begin
                b  = words[i][31-8*k -: 8];
                cs = cs ^ b;
                send_byte(b);
                if (k == 3) begin
                    chk_cnt++;
                    if (imem_we !== 1'b1 || imem_waddr !== ADDR_W'(i) || imem_wdata !== words[i]) begin
                        $display("FAIL write_%0d got we=%b a=%h d=%h exp we=1 a=%h d=%h",
                                 i, imem_we, imem_waddr, imem_wdata, ADDR_W'(i), words[i]);
                    end else pass_cnt++;
                end
                idle($urandom_range(0, maxgap));
            end
        end
        send_byte(cs ^ {7'b0, corrupt});
        chk_cnt++;
        if ({boot_pulse, cpu_hold, load_done, load_err} !== (corrupt ? 4'b0101 : 4'b1010)) begin
            $display("FAIL outcome got=%b exp=%b", {boot_pulse, cpu_hold, load_done, load_err},
                     corrupt ? 4'b0101 : 4'b1010);
        end else pass_cnt++;
        idle(2);
        chk_cnt++;
        if (boot_cnt !== (corrupt ? 0 : 1) || we_cnt !== int'(n)) begin
            $display("FAIL counts got boot=%0d we=%0d exp boot=%0d we=%0d", boot_cnt, we_cnt,
                     corrupt ? 0 : 1, n);
        end else pass_cnt++;
        bad = 0;
        for (int i = 0; i < int'(n); i++) if (mem_model[i] !== words[i]) bad++;
        chk_cnt++;
        if (bad != 0) $display("FAIL mem_image got %0d bad words exp 0", bad);
        else pass_cnt++;
        cpu_pc = $urandom;
        #1;
        chk_cnt++;
        if (imem_addr !== (corrupt ? ADDR_W'(n - 16'd1) : cpu_pc[ADDR_W+1:2])) begin
            $display("FAIL addr_mux got=%h exp=%h", imem_addr,
                     corrupt ? ADDR_W'(n - 16'd1) : cpu_pc[ADDR_W+1:2]);
        end else pass_cnt++;
    endtask

    task automatic check_reset_vals(input string tag);
        cpu_pc = $urandom;
        #1;
        chk_cnt++;
        if ({cpu_hold, imem_we, boot_pulse, load_done, load_err} !== 5'b0 ||
            imem_waddr !== '0 || imem_wdata !== 32'h0 || imem_addr !== cpu_pc[ADDR_W+1:2]) begin
            $display("FAIL %s got flags=%b wa=%h wd=%h addr=%h exp flags=00000 wa=0 wd=0 addr=%h",
                     tag, {cpu_hold, imem_we, boot_pulse, load_done, load_err}, imem_waddr,
                     imem_wdata, imem_addr, cpu_pc[ADDR_W+1:2]);
        end else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle(3);
        check_reset_vals("reset");
        reset = 1'b1;
        idle(1);
        check_reset_vals("after_reset");
    endtask

    task automatic test_good_load();
        words = '{32'h3C114000, 32'h26310004};
        run_frame(1'b0, 0, 0);
    endtask

    task automatic test_bad_csum();
        words = '{32'h3C114000, 32'h26310004};
        run_frame(1'b1, 2, 0);
    endtask

    task automatic test_bad_length(input logic [7:0] hi, input logic [7:0] lo);
        pulse_start();
        send_byte(8'hA5);
        send_byte(hi);
        send_byte(lo);
        chk_cnt++;
        if ({load_err, cpu_hold, load_done} !== 3'b110) begin
            $display("FAIL bad_len_%h%h got err/hold/done=%b exp=110", hi, lo,
                     {load_err, cpu_hold, load_done});
        end else pass_cnt++;
        idle(2);
        chk_cnt++;
        if (we_cnt !== 0) $display("FAIL bad_len_we got=%0d exp=0", we_cnt);
        else pass_cnt++;
    endtask

    task automatic test_noise();
        words = '{32'h3C114000, 32'h26310004};
        run_frame(1'b0, 1, 3);
    endtask

    task automatic test_timeout();
        int early;
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h3C);
        send_byte(8'h11);
        early = 0;
        for (int j = 1; j <= TIMEOUT; j++) begin
            start = (j == 5);
            @(negedge clk);
            start = 1'b0;
            if (j < TIMEOUT && load_err !== 1'b0) early++;
        end
        chk_cnt++;
        if (early != 0) $display("FAIL timeout_early got %0d early cycles exp 0", early);
        else pass_cnt++;
        chk_cnt++;
        if ({load_err, cpu_hold, load_done} !== 3'b110 || we_cnt !== 0) begin
            $display("FAIL timeout got err/hold/done=%b we=%0d exp=110 we=0",
                     {load_err, cpu_hold, load_done}, we_cnt);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid_data();
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h04);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("reset_mid_data");
        reset = 1'b1;
        idle(1);
        words.delete();
        for (int i = 0; i < 3; i++) words.push_back($urandom);
        run_frame(1'b0, 1, 0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            words.delete();
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) words.push_back($urandom);
            run_frame(1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 3));
        end
    endtask

    task automatic test_back_to_back_max();
        words.delete();
        for (int i = 0; i < 256; i++) words.push_back($urandom);
        run_frame(1'b0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_csum();
        test_bad_length(8'h00, 8'h00);
        test_bad_length(8'h01, 8'h01);
        test_noise();
        test_timeout();
        test_reset_mid_data();
        test_random();
        test_back_to_back_max();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
